// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 2-stage test-pattern pipeline (colour bars, grey ramp, white, pattern 11) with aligned timing strobes.
// Define VGA_PATTERN_CHECKER_EN to make pattern 11 a 32x32 checkerboard; otherwise pattern 11 is black.
module vga_pattern_gen #(
  parameter int H_disp = 1280,
  parameter int V_disp = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_n_in,
  input  logic       sync_n_in,
  input  logic       disp_enable,
  input  logic [1:0] pattern_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_tick
);
  localparam logic [10:0] X_MAX = 11'(H_disp - 1);
  localparam logic [10:0] Y_MAX = 11'(V_disp - 1);
  logic [10:0] x, y, s1_x, s1_y;
  logic de_d, de_rise, de_fall, armed, aligned, tick_done, s1_de, tick;
  logic [1:0] pat;
  logic [3:0] s1_sync;
  logic [2:0] bar;
  logic [23:0] bars, chk, rgb;
  always_comb begin
    de_rise = disp_enable & ~de_d;
    de_fall = de_d & ~disp_enable;
  end
  // vsync clears y ahead of any line-end increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      de_d <= 1'b0;
    end else begin
      de_d <= disp_enable;
      x <= !disp_enable ? '0 : x == X_MAX ? x : x + 11'd1;
      y <= !vsync_in ? '0 : !de_fall ? y : y == Y_MAX ? y : y + 11'd1;
    end
  // pattern changes only at the first active pixel of a frame; y is trusted only after a vsync
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed <= 1'b0;
      aligned <= 1'b0;
      pat <= 2'd0;
    end else begin
      armed <= !vsync_in ? 1'b1 : de_rise ? 1'b0 : armed;
      aligned <= aligned | ~vsync_in;
      pat <= armed && de_rise ? pattern_sel : pat;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_x <= '0;
      s1_y <= '0;
      s1_de <= 1'b0;
      s1_sync <= 4'hF;
    end else begin
      s1_x <= x;
      s1_y <= y;
      s1_de <= disp_enable & aligned;
      s1_sync <= {hsync_in, vsync_in, blank_n_in, sync_n_in};
    end
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if ({3'b000, s1_x, 3'b000} >= 17'(k * H_disp)) bar = bar + 3'd1;
    bars = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`ifdef VGA_PATTERN_CHECKER_EN
    chk = {24{~(s1_x[5] ^ s1_y[5])}};
`else
    chk = 24'h0;
`endif
    rgb = !s1_de ? 24'h0 : pat == 2'd0 ? bars : pat == 2'd1 ? {3{s1_x[9:2]}} : pat == 2'd2 ? 24'hFFFFFF : chk;
    tick = s1_de & (s1_x == X_MAX) & (s1_y == Y_MAX) & ~tick_done;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hsync, vsync, blank_n, sync_n} <= 4'hF;
      {vga_r, vga_g, vga_b} <= 24'h0;
      frame_tick <= 1'b0;
      tick_done <= 1'b0;
    end else begin
      {hsync, vsync, blank_n, sync_n} <= s1_sync;
      {vga_r, vga_g, vga_b} <= rgb;
      frame_tick <= tick;
      tick_done <= !vsync_in ? 1'b0 : tick ? 1'b1 : tick_done;
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized frames at full 1280-px width (40 lines) checked cycle by cycle against a pixel-level model.
module tb_vga_pattern_gen;
  localparam int H = 1280;
  localparam int V = 40;
  localparam int NF = 8;
  localparam logic [28:0] RST_V = {4'hF, 1'b0, 24'h0};
`ifdef VGA_PATTERN_CHECKER_EN
  localparam logic [23:0] CW = 24'hFFFFFF;
`else
  localparam logic [23:0] CW = 24'h0;
`endif
  typedef struct {
    logic [28:0] v;
    int px;
    int py;
    logic act;
    logic [1:0] pat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hs_i = 1'b1, vs_i = 1'b1, bn_i = 1'b0, sn_i = 1'b1, de = 1'b0;
  logic [1:0] psel = 2'd0;
  logic hsync, vsync, blank_n, sync_n, frame_tick;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [28:0] obs;
  int n_pass = 0, n_total = 0, n_ticks = 0;
  int col = 0, line = 0;
  logic aligned_m = 1'b0, armed_m = 1'b0;
  logic [1:0] pat_m = 2'd0;
  logic [1:0] plan [NF+1] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
  exp_t q[$];
  exp_t rst_e;

  vga_pattern_gen #(.H_disp(H), .V_disp(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_in(hs_i), .vsync_in(vs_i), .blank_n_in(bn_i), .sync_n_in(sn_i),
    .disp_enable(de), .pattern_sel(psel),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
  );

  assign obs = {hsync, vsync, blank_n, sync_n, frame_tick, vga_r, vga_g, vga_b};
  always #5 clk = ~clk;

  function automatic logic [23:0] colour(input int px, input int py, input logic [1:0] pat);
    if (pat == 2'd0)
      case (px * 8 / H)
        0: return 24'hFFFFFF;
        1: return 24'hFFFF00;
        2: return 24'h00FFFF;
        3: return 24'h00FF00;
        4: return 24'hFF00FF;
        5: return 24'hFF0000;
        6: return 24'h0000FF;
        default: return 24'h000000;
      endcase
    if (pat == 2'd1) return {3{8'((px % 1024) / 4)}};
    if (pat == 2'd2) return 24'hFFFFFF;
    return ((px / 32 + py / 32) % 2 == 0) ? CW : 24'h0;
  endfunction

  task automatic check(input string tag, input logic [28:0] got, input logic [28:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic dchk(input string tag, input bit cond, input logic [23:0] want);
    if (cond) check(tag, {5'd0, vga_r, vga_g, vga_b}, {5'd0, want});
  endtask

  task automatic cycle();
    exp_t e;
    int px, py;
    e = rst_e;
    if (!rst_n) begin
      aligned_m = 1'b0;
      armed_m = 1'b0;
      pat_m = 2'd0;
    end else begin
      if (de && armed_m) begin
        pat_m = psel;
        armed_m = 1'b0;
      end
      px = col < H ? col : H - 1;
      py = line < V ? line : V - 1;
      e.act = de && aligned_m;
      e.px = px;
      e.py = py;
      e.pat = pat_m;
      e.v = {hs_i, vs_i, bn_i, sn_i, e.act && px == H - 1 && py == V - 1, e.act ? colour(px, py, pat_m) : 24'h0};
      if (!vs_i) begin
        aligned_m = 1'b1;
        armed_m = 1'b1;
      end
    end
    q.push_back(e);
    void'(q.pop_front());
    @(posedge clk);
    #1;
    check($sformatf("pix(%0d,%0d) pat %0d", q[0].px, q[0].py, q[0].pat), obs, q[0].v);
    if (frame_tick === 1'b1) n_ticks++;
    dchk("bar_x0", q[0].act && q[0].pat == 2'd0 && q[0].px == 0, 24'hFFFFFF);
    dchk("bar_x160", q[0].act && q[0].pat == 2'd0 && q[0].px == 160, 24'hFFFF00);
    dchk("bar_x1279", q[0].act && q[0].pat == 2'd0 && q[0].px == 1279, 24'h000000);
    dchk("grey_x4", q[0].act && q[0].pat == 2'd1 && q[0].px == 4, 24'h010101);
    dchk("grey_x1023", q[0].act && q[0].pat == 2'd1 && q[0].px == 1023, 24'hFFFFFF);
    dchk("grey_x1024", q[0].act && q[0].pat == 2'd1 && q[0].px == 1024, 24'h000000);
    dchk("white_x640", q[0].act && q[0].pat == 2'd2 && q[0].px == 640, 24'hFFFFFF);
    dchk("chk_31_0", q[0].act && q[0].pat == 2'd3 && q[0].px == 31 && q[0].py == 0, CW);
    dchk("chk_32_0", q[0].act && q[0].pat == 2'd3 && q[0].px == 32 && q[0].py == 0, 24'h0);
    dchk("chk_32_32", q[0].act && q[0].pat == 2'd3 && q[0].px == 32 && q[0].py == 32, CW);
  endtask

  task automatic drive(input logic d, input logic h, input logic v);
    de = d;
    hs_i = h;
    vs_i = v;
    bn_i = d;
    sn_i = h & v;
    cycle();
  endtask

  task automatic blank(input int n, input int vs_from, input int vs_to);
    for (int c = 0; c < n; c++)
      drive(1'b0, !(c % 16 >= 2 && c % 16 < 6), !(c >= vs_from && c < vs_to));
  endtask

  task automatic run_line(input int l, input int len, input bit rst_mid);
    for (int c = 0; c < len; c++) begin
      col = c;
      line = l;
      if (rst_mid && c == 10) begin
        rst_n = 1'b0;
        q.delete();
        q.push_back(rst_e);
        q.push_back(rst_e);
      end
      if (rst_mid && c == 25) rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic run_frame(input int f, input bit rst_mid, input bit vs_at_fall);
    for (int l = 0; l < V; l++) begin
      if (l == 5) psel = 2'($urandom);
      if (l == V / 2) psel = plan[f + 1];
      run_line(l, l == 0 ? H + int'($urandom_range(0, 6)) : l == V - 1 ? H : int'($urandom_range(40, 96)), rst_mid && l == 20);
      if (l < V - 1) blank(int'($urandom_range(8, 16)), -1, -1);
    end
    if (vs_at_fall) blank(40, 0, 1);
    else blank(40, 6, 20);
  endtask

  initial begin
    rst_e.v = RST_V;
    rst_e.px = 0;
    rst_e.py = 0;
    rst_e.act = 1'b0;
    rst_e.pat = 2'd0;
    q.push_back(rst_e);
    q.push_back(rst_e);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("reset_state", obs, RST_V);
    rst_n = 1'b1;
    psel = plan[0];
    blank(30, 5, 15);
    for (int f = 0; f < NF; f++) run_frame(f, f == 5, f == 2);
    blank(10, -1, -1);
    check("tick_count", 29'(n_ticks), 29'(NF - 1));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_disp, default 1280, active pixels per line.
REQ-002 Parameter V_disp, default 1024, active lines per frame.
REQ-003 clk  input  1  pixel clock, the same clock that drives the timing generator.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hsync_in, vsync_in, blank_n_in, sync_n_in  input  1 each  raw timing strobes from the timing generator; sync pulses are active-low.
REQ-006 disp_enable  input  1  high during active pixels.
REQ-007 pattern_sel  input  2  requested test pattern.
REQ-008 hsync, vsync, blank_n, sync_n  output  1 each  timing strobes delayed to align with the colour outputs.
REQ-009 vga_r, vga_g, vga_b  output  8 each  pixel colour.
REQ-010 frame_tick  output  1  one-cycle pulse, aligned with the last active pixel of a frame at the outputs.

Function
REQ-011 Internal coordinates: x and y, 11 bits each.
REQ-012 x SHALL increment on every cycle with disp_enable high, and SHALL clear to 0 on the cycle after disp_enable falls.
REQ-013 x SHALL saturate at H_disp-1 if disp_enable stays high longer than H_disp cycles.
REQ-014 y SHALL increment on each falling edge of disp_enable.
REQ-015 y SHALL saturate at V_disp-1.
REQ-016 y SHALL clear to 0 while vsync_in is low; this clear takes priority over the increment.
REQ-017 pattern_sel SHALL be sampled into an active-pattern register only on the first rising edge of disp_enable after vsync_in deasserts, so a change never tears a frame.
REQ-018 Pipeline stage 1 registers x, y and disp_enable; stage 2 registers the colour. Total latency from inputs to outputs is 2 cycles.
REQ-019 hsync, vsync, blank_n, sync_n and frame_tick SHALL pass through an identical 2-stage delay so all outputs stay cycle-aligned.
REQ-020 vga_r, vga_g and vga_b SHALL all be 0 whenever the 2-cycle-delayed disp_enable is low.
REQ-021 Pattern 00, colour bars: bar index = x*8/H_disp, giving 160-px bars at the default width.
REQ-022 Bar order, index 0 to 7: white, yellow, cyan, green, magenta, red, blue, black; components are 8'hFF or 8'h00.
REQ-023 Pattern 01, grey ramp: vga_r = vga_g = vga_b = x[9:2], which wraps every 1024 px.
REQ-024 Pattern 10: solid white, all components 8'hFF.
REQ-025 Pattern 11: behaviour is set by the Configuration section.
REQ-026 frame_tick SHALL be high for exactly one cycle, when the pixel at x = H_disp-1, y = V_disp-1 appears at the outputs.
REQ-027 Simultaneous vsync_in low and a disp_enable falling edge: y SHALL become 0.

Reset
REQ-028 With rst_n low, all of the following SHALL be 0: x, y, both pipeline stages, vga_r, vga_g, vga_b, frame_tick.
REQ-029 With rst_n low, hsync, vsync, blank_n and sync_n SHALL be 1 (inactive); the active pattern SHALL be 00.
REQ-030 Reset deasserted mid-frame: outputs SHALL be black until y is realigned by the next vsync_in low.
REQ-031 Reset deasserted mid-frame: frame_tick SHALL NOT fire before that realignment.

Configuration
REQ-032 With macro VGA_PATTERN_CHECKER_EN defined, pattern 11 SHALL be a 32x32 checkerboard: white when x[5] XOR y[5] = 0, otherwise black.
REQ-033 Without VGA_PATTERN_CHECKER_EN, pattern 11 SHALL output solid black, and no checker logic SHALL be synthesised.

Verification
REQ-034 Reset, then full 1280x1024 frame with pattern_sel=00 -> at output pixel x=0 the colour is FF/FF/FF; at x=160 it is FF/FF/00; at x=1279 it is 00/00/00; outputs lag disp_enable by exactly 2 cycles.
REQ-035 pattern_sel=01 -> at x=4 the output is 01/01/01; at x=1023 it is FF/FF/FF; at x=1024 it is 00/00/00.
REQ-036 Change pattern_sel from 00 to 10 mid-frame -> the remaining frame stays colour bars; the next frame is all FF.
REQ-037 Two full frames -> frame_tick pulses exactly once per frame, 2 cycles after the input cycle of x=1279, y=1023; delayed vsync equals vsync_in shifted by 2 cycles.
REQ-038 pattern_sel=11 with VGA_PATTERN_CHECKER_EN -> (x=31, y=0) is white, (32, 0) is black, (32, 32) is white; without the macro, all pixels are 00.
REQ-039 Assert rst_n low at line 500, release it mid-line -> outputs are black and blank_n is 1 during reset; the first frame_tick occurs only after the next full frame.
